// File: rtl/alu_pkg.sv
// alu_pkg: shared operand width default, ALU op code constants and the
// illegal-op check used by alu_arbiter to mask undefined select codes.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] OP_AND    = 4'b0000;
    localparam logic [3:0] OP_OR     = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_ADD    = 4'b0011;
    localparam logic [3:0] OP_SUB    = 4'b0100;
    localparam logic [3:0] OP_PASS_B = 4'b0110;
    localparam logic [3:0] OP_SLL    = 4'b0111;
    localparam logic [3:0] OP_SRL    = 4'b1000;
    localparam logic [3:0] OP_SRA    = 4'b1001;
    localparam logic [3:0] OP_SLA    = 4'b1010;
    localparam logic [3:0] OP_SLTU   = 4'b1011;
    localparam logic [3:0] OP_SLT    = 4'b1100;

    // Codes 0101, 1101, 1110 and 1111 have no defined operation.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op == 4'b0101) || (op == 4'b1101) || (op == 4'b1110) || (op == 4'b1111);
    endfunction

endpackage

// File: rtl/alu.sv
// alu: the shared combinational ALU. Shift amount is b[4:0]; SLA shifts
// left exactly like SLL. Undefined codes produce 0 here as well, although
// the arbiter masks them independently.
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      op_i,
    input  logic            sign_i,
    output logic [XLEN-1:0] result_o
);

    logic [4:0] shamt;
    logic       unused_sign;

    assign shamt       = b_i[4:0];
    // Signedness is carried by the op code itself; the hint is accepted but unused.
    assign unused_sign = sign_i;

    // Operation select.
    always_comb begin
        result_o = '0;
        case (op_i)
            OP_AND:    result_o = a_i & b_i;
            OP_OR:     result_o = a_i | b_i;
            OP_XOR:    result_o = a_i ^ b_i;
            OP_ADD:    result_o = a_i + b_i;
            OP_SUB:    result_o = a_i - b_i;
            OP_PASS_B: result_o = b_i;
            OP_SLL:    result_o = a_i << shamt;
            OP_SRL:    result_o = a_i >> shamt;
            OP_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
            OP_SLA:    result_o = a_i << shamt;
            OP_SLTU:   result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            OP_SLT:    result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU. At most one operation is
// accepted per cycle; each requester has a one-deep registered response.
// Handshake: a transfer happens on a rising edge where valid && ready; a
// response stays valid until the requester's rsp ready is high in a cycle
// with no new accept for it.
// Configuration macro: ALU_ARB_ROUND_ROBIN_EN selects round-robin priority;
// without it requester 0 has strict priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req0_valid,
    output logic            o_req0_ready,
    input  logic [XLEN-1:0] i_req0_a,
    input  logic [XLEN-1:0] i_req0_b,
    input  logic [3:0]      i_req0_op,
    input  logic            i_req0_sign,
    input  logic            i_req1_valid,
    output logic            o_req1_ready,
    input  logic [XLEN-1:0] i_req1_a,
    input  logic [XLEN-1:0] i_req1_b,
    input  logic [3:0]      i_req1_op,
    input  logic            i_req1_sign,
    output logic            o_rsp0_valid,
    input  logic            i_rsp0_ready,
    output logic [XLEN-1:0] o_rsp0_result,
    output logic            o_rsp0_zero,
    output logic            o_rsp1_valid,
    input  logic            i_rsp1_ready,
    output logic [XLEN-1:0] o_rsp1_result,
    output logic            o_rsp1_zero
);

    logic            pri_q, pri_d;
    logic            elig0, elig1;
    logic            grant0, grant1;
    logic            acc0, acc1;
    logic [XLEN-1:0] alu_a, alu_b, alu_res, res_masked;
    logic [3:0]      alu_op;
    logic            alu_sign;

    // Eligibility and grant: PRI wins a tie, a lone eligible requester always wins.
    always_comb begin
        elig0  = i_req0_valid && (!o_rsp0_valid || i_rsp0_ready);
        elig1  = i_req1_valid && (!o_rsp1_valid || i_rsp1_ready);
        grant0 = elig0 && (!elig1 || !pri_q);
        grant1 = elig1 && !grant0;
    end

    // Ready is forced low while reset is asserted.
    assign o_req0_ready = grant0 && i_rst_n;
    assign o_req1_ready = grant1 && i_rst_n;
    assign acc0         = i_req0_valid && o_req0_ready;
    assign acc1         = i_req1_valid && o_req1_ready;

    // Operand mux in front of the shared ALU; requester 0 is the idle default.
    always_comb begin
        alu_a    = o_req1_ready ? i_req1_a    : i_req0_a;
        alu_b    = o_req1_ready ? i_req1_b    : i_req0_b;
        alu_op   = o_req1_ready ? i_req1_op   : i_req0_op;
        alu_sign = o_req1_ready ? i_req1_sign : i_req0_sign;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .sign_i   (alu_sign),
        .result_o (alu_res)
    );

    // Undefined op codes always yield 0, never a leftover value.
    assign res_masked = is_illegal_op(alu_op) ? '0 : alu_res;

    // Priority pointer next state.
    always_comb begin
        pri_d = pri_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (acc0)      pri_d = 1'b1;
        else if (acc1) pri_d = 1'b0;
`endif
    end

    // Priority pointer register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) pri_q <= 1'b0;
        else          pri_q <= pri_d;
    end

    // Requester 0 response register: a new accept overrides a same-cycle drain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp0_valid  <= 1'b0;
            o_rsp0_result <= '0;
            o_rsp0_zero   <= 1'b0;
        end else if (acc0) begin
            o_rsp0_valid  <= 1'b1;
            o_rsp0_result <= res_masked;
            o_rsp0_zero   <= (res_masked == '0);
        end else if (i_rsp0_ready) begin
            o_rsp0_valid  <= 1'b0;
        end
    end

    // Requester 1 response register: a new accept overrides a same-cycle drain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp1_valid  <= 1'b0;
            o_rsp1_result <= '0;
            o_rsp1_zero   <= 1'b0;
        end else if (acc1) begin
            o_rsp1_valid  <= 1'b1;
            o_rsp1_result <= res_masked;
            o_rsp1_zero   <= (res_masked == '0);
        end else if (i_rsp1_ready) begin
            o_rsp1_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed stimulus against a behavioural
// model of the two-requester arbiter and its ALU.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_sign, req1_sign;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_ready, rsp1_ready;
    logic        o_req0_ready, o_req1_ready;
    logic        o_rsp0_valid, o_rsp1_valid, o_rsp0_zero, o_rsp1_zero;
    logic [31:0] o_rsp0_result, o_rsp1_result;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic        m_pri;
    logic        m_v [2];
    logic [31:0] m_res [2];
    logic        last_g0, last_g1;

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req0_valid  (req0_valid),
        .o_req0_ready  (o_req0_ready),
        .i_req0_a      (req0_a),
        .i_req0_b      (req0_b),
        .i_req0_op     (req0_op),
        .i_req0_sign   (req0_sign),
        .i_req1_valid  (req1_valid),
        .o_req1_ready  (o_req1_ready),
        .i_req1_a      (req1_a),
        .i_req1_b      (req1_b),
        .i_req1_op     (req1_op),
        .i_req1_sign   (req1_sign),
        .o_rsp0_valid  (o_rsp0_valid),
        .i_rsp0_ready  (rsp0_ready),
        .o_rsp0_result (o_rsp0_result),
        .o_rsp0_zero   (o_rsp0_zero),
        .o_rsp1_valid  (o_rsp1_valid),
        .i_rsp1_ready  (rsp1_ready),
        .o_rsp1_result (o_rsp1_result),
        .o_rsp1_zero   (o_rsp1_zero)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic signed [31:0] sa;
        sh = b % 32;
        sa = a;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a ^ b;
            4'd3:  return a + b;
            4'd4:  return a - b;
            4'd6:  return b;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return sa >>> sh;
            4'd10: return a << sh;
            4'd11: return (a < b) ? 32'd1 : 32'd0;
            4'd12: return (sa < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pri = 1'b0;
        m_v[0] = 1'b0; m_v[1] = 1'b0;
        m_res[0] = '0; m_res[1] = '0;
    endtask

    task automatic set_req(input int n, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_sign = op[0];
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_sign = op[0];
        end
    endtask

    // One cycle: called just after a falling edge with inputs driven.
    // Checks ready against the model, advances the model at the rising
    // edge, then checks the registered responses at the next falling edge.
    task automatic step();
        logic e0, e1, g0, g1;
        logic [31:0] r;
        #1;
        e0 = req0_valid && (!m_v[0] || rsp0_ready);
        e1 = req1_valid && (!m_v[1] || rsp1_ready);
        if (e0 && e1) begin
            g0 = (m_pri == 1'b0);
            g1 = !g0;
        end else begin
            g0 = e0;
            g1 = e1;
        end
        chk("req0_ready", {31'd0, o_req0_ready}, {31'd0, g0});
        chk("req1_ready", {31'd0, o_req1_ready}, {31'd0, g1});
        last_g0 = g0;
        last_g1 = g1;
        @(posedge clk);
        if (g0) begin
            r = ref_alu(req0_op, req0_a, req0_b);
            m_v[0] = 1'b1; m_res[0] = r;
        end else if (rsp0_ready) m_v[0] = 1'b0;
        if (g1) begin
            r = ref_alu(req1_op, req1_a, req1_b);
            m_v[1] = 1'b1; m_res[1] = r;
        end else if (rsp1_ready) m_v[1] = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (g0) m_pri = 1'b1;
        else if (g1) m_pri = 1'b0;
`endif
        @(negedge clk);
        chk("rsp0_valid", {31'd0, o_rsp0_valid}, {31'd0, m_v[0]});
        chk("rsp1_valid", {31'd0, o_rsp1_valid}, {31'd0, m_v[1]});
        if (m_v[0]) begin
            chk("rsp0_result", o_rsp0_result, m_res[0]);
            chk("rsp0_zero", {31'd0, o_rsp0_zero}, {31'd0, (m_res[0] == 32'd0)});
        end
        if (m_v[1]) begin
            chk("rsp1_result", o_rsp1_result, m_res[1]);
            chk("rsp1_zero", {31'd0, o_rsp1_zero}, {31'd0, (m_res[1] == 32'd0)});
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] held;
    int          grant_seq [4];

    initial begin
        model_reset();
        rst_n = 1'b0;
        set_req(0, 1'b1, 4'd3, 32'd1, 32'd2);
        set_req(1, 1'b1, 4'd3, 32'd3, 32'd4);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_req0_ready", {31'd0, o_req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, o_req1_ready}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, o_rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, o_rsp1_valid}, 32'd0);
        chk("rst_rsp0_result", o_rsp0_result, 32'd0);
        chk("rst_rsp1_zero", {31'd0, o_rsp1_zero}, 32'd0);
        rst_n = 1'b1;

        // req0 ADD alone wraps to zero
        set_req(0, 1'b1, 4'd3, 32'h0000_0005, 32'hFFFF_FFFB);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        step();
        chk("add_wrap_valid", {31'd0, o_rsp0_valid}, 32'd1);
        chk("add_wrap_result", o_rsp0_result, 32'd0);
        chk("add_wrap_zero", {31'd0, o_rsp0_zero}, 32'd1);

        // req1 SRA / SLT / SLTU
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b1, 4'd9, 32'h8000_0000, 32'h0000_0024);
        step();
        chk("sra_result", o_rsp1_result, 32'hF800_0000);
        set_req(1, 1'b1, 4'd12, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("slt_result", o_rsp1_result, 32'd1);
        set_req(1, 1'b1, 4'd11, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("sltu_result", o_rsp1_result, 32'd0);
        chk("sltu_zero", {31'd0, o_rsp1_zero}, 32'd1);

        // illegal op after a nonzero result leaves no stale value
        set_req(1, 1'b1, 4'd1, 32'd7, 32'd9);
        step();
        chk("or_result", o_rsp1_result, 32'd15);
        set_req(1, 1'b1, 4'b1101, 32'd7, 32'd9);
        step();
        chk("illegal_result", o_rsp1_result, 32'd0);
        chk("illegal_zero", {31'd0, o_rsp1_zero}, 32'd1);

        // req0 held for 5 cycles while req1 keeps being served
        set_req(0, 1'b1, 4'd2, 32'h1234_5678, 32'h0F0F_0F0F);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        step();
        held = o_rsp0_result;
        chk("hold_first", held, 32'h1D3B_5977);
        rsp0_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(0, 1'b1, 4'd3, $urandom, $urandom);
            set_req(1, 1'b1, 4'd3, i, 32'd100);
            step();
            chk("hold_req0_ready", {31'd0, last_g0}, 32'd0);
            chk("hold_req1_served", {31'd0, last_g1}, 32'd1);
            chk("hold_stable", o_rsp0_result, held);
            chk("hold_req1_result", o_rsp1_result, i + 100);
        end
        rsp0_ready = 1'b1;

        // reset mid-operation with rsp1 held
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b1, 4'd6, 32'd0, 32'hCAFE_F00D);
        rsp1_ready = 1'b0;
        step();
        chk("pre_rst_rsp1_valid", {31'd0, o_rsp1_valid}, 32'd1);
        set_req(0, 1'b1, 4'd0, 32'd0, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp1_valid", {31'd0, o_rsp1_valid}, 32'd0);
        chk("midrst_rsp1_result", o_rsp1_result, 32'd0);
        chk("midrst_req0_ready", {31'd0, o_req0_ready}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rsp1_ready = 1'b1;

        // both valid every cycle after release: first grant to req0
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, 4'd3, 32'd10, i);
            set_req(1, 1'b1, 4'd4, 32'd10, i);
            step();
            grant_seq[i] = last_g1 ? 1 : 0;
        end
        chk("both_first_grant", grant_seq[0], 32'd0);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        chk("rr_grant1", grant_seq[1], 32'd1);
        chk("rr_grant2", grant_seq[2], 32'd0);
        chk("rr_grant3", grant_seq[3], 32'd1);
`else
        chk("fixed_grant1", grant_seq[1], 32'd0);
        chk("fixed_grant2", grant_seq[2], 32'd0);
        chk("fixed_grant3", grant_seq[3], 32'd0);
`endif

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            set_req(0, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
            set_req(1, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), rand_operand(), rand_operand());
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 supported.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 o_reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 i_reqN_a, i_reqN_b  input  XLEN each  operands 1 and 2 for requester N.
REQ-007 i_reqN_op  input  4  ALU select code for requester N.
REQ-008 i_reqN_sign  input  1  signedness hint, forwarded to the ALU unchanged.
REQ-009 o_rspN_valid  output  1  result held for requester N.
REQ-010 i_rspN_ready  input  1  requester N consumes its result this cycle.
REQ-011 o_rspN_result  output  XLEN  ALU result for requester N.
REQ-012 o_rspN_zero  output  1  zero flag for requester N (1 when result == 0).

Function
REQ-013 One shared ALU instance SHALL serve both requesters, at most one accept per cycle.
REQ-014 Transfer occurs on a rising edge where i_reqN_valid && o_reqN_ready; response registered at that edge, o_rspN_valid high the next cycle (latency 1).
REQ-015 Requester N eligible when i_reqN_valid && (!o_rspN_valid || i_rspN_ready).
REQ-016 o_reqN_ready = grant_N && eligible_N; at most one ready high per cycle; o_reqN_ready SHALL NOT depend combinationally on i_reqN_a/b/op/sign.
REQ-017 o_rspN_valid SHALL stay high, with result/zero stable, until a cycle with i_rspN_ready high and no new accept for N.
REQ-018 Drain and new accept for N in the same cycle: o_rspN_valid stays high, new result replaces old.
REQ-019 Valid op codes: 0000 AND, 0001 OR, 0010 XOR, 0011 ADD, 0100 SUB, 0110 PASS_B, 0111 SLL, 1000 SRL, 1001 SRA, 1010 SLA, 1011 SLTU, 1100 SLT; shift amount = b[4:0]; SLT/SLTU yield 0 or 1.
REQ-020 Illegal codes (0101, 1101, 1110, 1111) SHALL be accepted and produce result 0, zero 1; never a held/latched prior value.
REQ-021 Arithmetic wraps modulo 2^32; no carry/overflow output.
REQ-022 Arbitration state: one-bit priority pointer PRI; PRI names the requester tried first.
REQ-023 Both eligible: PRI wins; only one eligible: it wins; none: no grant, PRI unchanged.
REQ-024 PRI updates only on an accept, per Configuration.

Reset
REQ-025 Asserting i_rst_n low SHALL immediately clear o_rspN_valid, o_rspN_result (0), o_rspN_zero (0), PRI (0).
REQ-026 Reset mid-operation drops held results silently; first accept after release follows PRI=0.
REQ-027 While i_rst_n is low o_reqN_ready SHALL be 0.

Configuration
REQ-028 Macro ALU_ARB_ROUND_ROBIN_EN defined: after an accept by N, PRI becomes 1-N (round-robin, starvation-free).
REQ-029 Macro undefined: PRI fixed at 0 (requester 0 strict priority); requester 1 granted only when requester 0 is not eligible.

Structure
REQ-030 Shared package alu_pkg SHALL hold the 4-bit op code constants, the illegal-code check function, and XLEN default.
REQ-031 One sub-module: alu, the existing combinational ALU, instantiated once behind an operand mux; illegal-op masking lives in alu_arbiter.
REQ-032 Arbitration and response registers are per-requester duplicated logic, no further sub-modules.

Verification
REQ-033 Req0 ADD a=0x0000_0005 b=0xFFFF_FFFB alone -> next cycle o_rsp0_valid=1, result=0, zero=1.
REQ-034 Both valid every cycle, rsp ready high, RR build -> grants alternate 0,1,0,1 starting with 0; fixed build -> only req0 granted while valid.
REQ-035 Req1 SRA a=0x8000_0000 b=0x0000_0024 -> result=0xF800_0000 (shift 4); SLT a=0xFFFF_FFFF b=1 -> 1; SLTU same operands -> 0.
REQ-036 Req0 result held, i_rsp0_ready=0 for 5 cycles -> o_req0_ready=0, result stable; req1 still served each cycle.
REQ-037 Op 1101 with a=7 b=9 -> result=0, zero=1, no stale value.
REQ-038 i_rst_n low for one cycle while o_rsp1_valid=1 -> valid drops at once; after release both valid -> req0 granted first.
